// File: rtl/tlb_param.sv
// Parametrised fully-associative TLB: fetch/data translation, tlbr/tlbw/tlbi,
// fill-invalid-first allocation and a multi-cycle flush-by-PID sweep.
module tlb_param #(
  parameter int ENTRIES = 16,
  parameter int PA_W    = 27
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_en,
  input  logic            kmode,
  input  logic [31:0]     pid,
  input  logic [31:0]     addr0,
  input  logic [31:0]     addr1,
  input  logic            addr1_read_req,
  input  logic            addr1_write_req,
  input  logic [7:0]      exc_in,
  input  logic [31:0]     read_addr,
  input  logic            we,
  input  logic [31:0]     write_data,
  input  logic            invalidate,
  input  logic            clear,
  input  logic            flush_pid,
  output logic            busy,
  output logic [7:0]      exc_out0,
  output logic [7:0]      exc_out1,
  output logic [PA_W-1:0] addr0_out,
  output logic [PA_W-1:0] addr1_out,
  output logic [PA_W-1:0] read_addr_out
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic {IDLE, SWEEP} state_t;

  logic [ENTRIES-1:0] valid;
  logic [31:0]        tag [ENTRIES];
  logic [19:0]        vpn [ENTRIES];
  logic [PA_W-1:0]    val [ENTRIES];
  logic [IDX_W-1:0]   victim;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [31:0]        ftag, ftag_n;
  state_t             state, state_n;

  // {hit, value}; private match overrides global, lowest index wins in each
  function automatic logic [PA_W:0] lookup(input logic [19:0] v);
    logic [PA_W:0] r;
    r = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (valid[i] && val[i][4] && vpn[i] == v) r = {1'b1, val[i]};
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (valid[i] && tag[i] == pid && vpn[i] == v) r = {1'b1, val[i]};
    return r;
  endfunction

  logic [PA_W:0] lk0, lk1, lkr;
  assign lk0 = lookup(addr0[31:12]);
  assign lk1 = lookup(addr1[31:12]);
  assign lkr = lookup(read_addr[31:12]);

  logic            byp0, byp1, perm1, fault1;
  logic [7:0]      code, exc0_n, exc1_n;
  logic [PA_W-1:0] a0_n, a1_n, ar_n;

  always_comb begin
    byp0   = kmode && ((addr0 >> PA_W) == 32'd0);
    byp1   = kmode && ((addr1 >> PA_W) == 32'd0);
    code   = kmode ? 8'h83 : 8'h82;
    exc0_n = '0;
    a0_n   = '0;
    if (byp0) begin
      a0_n = addr0[PA_W-1:0];
    end else begin
      if (lk0[PA_W]) a0_n = {lk0[PA_W-1:12], addr0[11:0]};
      if (!lk0[PA_W] || !lk0[2] || (!kmode && !lk0[3])) exc0_n = code;
    end
    perm1  = addr1_write_req ? lk1[1] : lk1[0];
    fault1 = !byp1 && (addr1_read_req || addr1_write_req) &&
             (!lk1[PA_W] || (!kmode && !lk1[3]) || !perm1);
    exc1_n = (exc_in != 8'd0) ? exc_in : (fault1 ? code : 8'd0);
    if (exc_out1 != 8'd0)
      a1_n = PA_W'({exc_out1, 2'b00});
    else if (!byp1 && lk1[PA_W])
      a1_n = {lk1[PA_W-1:12], addr1[11:0]};
    else
      a1_n = addr1[PA_W-1:0];
    ar_n = lkr[PA_W] ? lkr[PA_W-1:0] : '0;
  end

  logic               w_hit, f_hit, evict;
  logic [IDX_W-1:0]   w_idx, f_idx, slot;
  logic [ENTRIES-1:0] inv_hit;

  always_comb begin
    w_hit   = 1'b0;
    f_hit   = 1'b0;
    w_idx   = '0;
    f_idx   = '0;
    inv_hit = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && vpn[i] == read_addr[31:12] &&
          (write_data[4] ? val[i][4] : (!val[i][4] && tag[i] == pid))) begin
        w_hit = 1'b1;
        w_idx = IDX_W'(i);
      end
      if (!valid[i]) begin
        f_hit = 1'b1;
        f_idx = IDX_W'(i);
      end
      inv_hit[i] = valid[i] && vpn[i] == read_addr[31:12] &&
                   (val[i][4] || tag[i] == pid);
    end
    evict = !w_hit && !f_hit;
    slot  = w_hit ? w_idx : (f_hit ? f_idx : victim);
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    ftag_n  = ftag;
    if (clear) begin
      state_n = IDLE;
      idx_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (flush_pid) begin
            state_n = SWEEP;
            idx_n   = '0;
            ftag_n  = pid;
          end
        end
        SWEEP: begin
          if (idx == IDX_W'(ENTRIES - 1)) state_n = IDLE;
          idx_n = idx + IDX_W'(1);
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy = (state == SWEEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid         <= '0;
      victim        <= '0;
      state         <= IDLE;
      idx           <= '0;
      ftag          <= '0;
      exc_out0      <= '0;
      exc_out1      <= '0;
      addr0_out     <= '0;
      addr1_out     <= '0;
      read_addr_out <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag[i] <= '0;
        vpn[i] <= '0;
        val[i] <= '0;
      end
    end else if (clk_en) begin
      state         <= state_n;
      idx           <= idx_n;
      ftag          <= ftag_n;
      exc_out0      <= exc0_n;
      exc_out1      <= exc1_n;
      addr0_out     <= a0_n;
      addr1_out     <= a1_n;
      read_addr_out <= ar_n;
      if (clear) begin
        valid  <= '0;
        victim <= '0;
      end else if (state == SWEEP) begin
        if (valid[idx] && !val[idx][4] && tag[idx] == ftag)
          valid[idx] <= 1'b0;
      end else if (flush_pid) begin
        valid <= valid;
      end else if (invalidate) begin
        valid <= valid & ~inv_hit;
      end else if (we) begin
        valid[slot] <= 1'b1;
        tag[slot]   <= pid;
        vpn[slot]   <= read_addr[31:12];
        val[slot]   <= write_data[PA_W-1:0];
        if (evict) victim <= victim + IDX_W'(1);
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{read_addr[11:0], write_data, lk0, lk1};

endmodule

// File: tb/tb_tlb_param.sv
// Directed bench for tlb_param (ENTRIES=16, PA_W=27) with immediate assertions.
module tb_tlb_param;

  localparam int PA_W = 27;

  logic            clk = 1'b0;
  logic            rst, clk_en, kmode;
  logic [31:0]     pid, addr0, addr1, read_addr, write_data;
  logic            addr1_read_req, addr1_write_req;
  logic [7:0]      exc_in;
  logic            we, invalidate, clear, flush_pid;
  logic            busy;
  logic [7:0]      exc_out0, exc_out1;
  logic [PA_W-1:0] addr0_out, addr1_out, read_addr_out;

  int vectors = 0;
  int miscompares = 0;
  int cnt;

  tlb_param #(.ENTRIES(16), .PA_W(PA_W)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .kmode(kmode), .pid(pid),
    .addr0(addr0), .addr1(addr1),
    .addr1_read_req(addr1_read_req), .addr1_write_req(addr1_write_req),
    .exc_in(exc_in), .read_addr(read_addr), .we(we),
    .write_data(write_data), .invalidate(invalidate), .clear(clear),
    .flush_pid(flush_pid), .busy(busy),
    .exc_out0(exc_out0), .exc_out1(exc_out1),
    .addr0_out(addr0_out), .addr1_out(addr1_out),
    .read_addr_out(read_addr_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string t, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", t, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] p, input logic [31:0] va,
                    input logic [31:0] d);
    pid = p;
    read_addr = va;
    write_data = d;
    we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input string t, input logic [31:0] p,
                    input logic [31:0] va, input logic [31:0] exp);
    pid = p;
    read_addr = va;
    tick();
    chk(t, 32'(read_addr_out), exp);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; kmode = 1'b0; pid = '0;
    addr0 = '0; addr1 = '0; addr1_read_req = 1'b0;
    addr1_write_req = 1'b0; exc_in = '0; read_addr = '0;
    we = 1'b0; write_data = '0; invalidate = 1'b0;
    clear = 1'b0; flush_pid = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_exc0", 32'(exc_out0), 32'd0);
    chk("rst_exc1", 32'(exc_out1), 32'd0);
    chk("rst_a0", 32'(addr0_out), 32'd0);
    chk("rst_a1", 32'(addr1_out), 32'd0);
    chk("rst_ra", 32'(read_addr_out), 32'd0);
    rst = 1'b0;

    // basic user fetch translation
    wr(32'd5, 32'h0040_0000, 32'h0000_301F);
    addr0 = 32'h0040_0ABC;
    tick();
    chk("fetch_a0", 32'(addr0_out), 32'h0000_3ABC);
    chk("fetch_exc0", 32'(exc_out0), 32'd0);

    // fill all slots, then evict via victim pointer
    do_clear();
    for (int i = 0; i < 16; i++)
      wr(32'd5, 32'h0010_0000 + (i << 12), ((i + 1) << 12) | 32'h0F);
    wr(32'd5, 32'h0020_0000, 32'h0000_A00F);
    rd("evict_old", 32'd5, 32'h0010_0000, 32'd0);
    rd("evict_new", 32'd5, 32'h0020_0000, 32'h0000_A00F);
    rd("evict_keep", 32'd5, 32'h0010_1000, 32'h0000_200F);
    wr(32'd5, 32'h0020_1000, 32'h0000_B00F);
    rd("victim_adv", 32'd5, 32'h0010_1000, 32'd0);
    rd("victim_keep", 32'd5, 32'h0010_2000, 32'h0000_300F);

    // read-only user page: write faults, read passes
    do_clear();
    wr(32'd5, 32'h0050_0000, 32'h0000_7009);
    addr1 = 32'h0050_0123;
    addr1_write_req = 1'b1;
    tick();
    chk("wr_exc1", 32'(exc_out1), 32'h82);
    chk("wr_a1", 32'(addr1_out), 32'h0000_7123);
    tick();
    chk("vec_a1", 32'(addr1_out), 32'h208);
    addr1_write_req = 1'b0;
    addr1_read_req = 1'b1;
    tick();
    chk("rd_exc1", 32'(exc_out1), 32'd0);
    chk("rd_vec_a1", 32'(addr1_out), 32'h208);
    tick();
    chk("rd_a1", 32'(addr1_out), 32'h0000_7123);
    addr1_read_req = 1'b0;
    exc_in = 8'h44;
    tick();
    chk("exc_in", 32'(exc_out1), 32'h44);
    exc_in = 8'h00;

    // kernel bypass and kernel miss
    do_clear();
    kmode = 1'b1;
    addr0 = 32'h0000_1000;
    tick();
    chk("byp_a0", 32'(addr0_out), 32'h0000_1000);
    chk("byp_exc0", 32'(exc_out0), 32'd0);
    addr0 = 32'h8000_0000;
    tick();
    chk("kmiss_exc0", 32'(exc_out0), 32'h83);
    chk("kmiss_a0", 32'(addr0_out), 32'd0);
    clk_en = 1'b0;
    addr0 = 32'h0000_1000;
    tick();
    chk("stall_exc0", 32'(exc_out0), 32'h83);
    clk_en = 1'b1;
    kmode = 1'b0;

    // flush pid 7: private slots 2,9 go, global slot 4 stays
    for (int i = 0; i < 16; i++) begin
      if (i == 2 || i == 9)
        wr(32'd7, 32'h0030_0000 + (i << 12), (i << 12) | 32'h0F);
      else if (i == 4)
        wr(32'd7, 32'h0030_0000 + (i << 12), (i << 12) | 32'h1F);
      else
        wr(32'd3, 32'h0030_0000 + (i << 12), (i << 12) | 32'h0F);
    end
    pid = 32'd7;
    flush_pid = 1'b1;
    tick();
    flush_pid = 1'b0;
    chk("flush_busy", 32'(busy), 32'd1);
    wr(32'd7, 32'h003F_F000, 32'h0000_5F0F);
    cnt = 1;
    if (busy) cnt++;
    for (int k = 0; k < 40 && busy; k++) begin
      tick();
      if (busy) cnt++;
    end
    chk("busy_len", cnt, 32'd16);
    chk("busy_done", 32'(busy), 32'd0);
    rd("flush_s2", 32'd7, 32'h0030_2000, 32'd0);
    rd("flush_s9", 32'd7, 32'h0030_9000, 32'd0);
    rd("flush_g4", 32'd7, 32'h0030_4000, 32'h0000_401F);
    rd("flush_p3", 32'd3, 32'h0030_1000, 32'h0000_100F);
    rd("busy_we", 32'd7, 32'h003F_F000, 32'd0);

    // clear aborts a sweep
    pid = 32'd3;
    flush_pid = 1'b1;
    tick();
    flush_pid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("sweep5_busy", 32'(busy), 32'd1);
    do_clear();
    chk("clr_busy", 32'(busy), 32'd0);
    rd("clr_p3", 32'd3, 32'h0030_1000, 32'd0);
    rd("clr_g4", 32'd3, 32'h0030_4000, 32'd0);

    // invalidate frees a slot that the next write reuses
    for (int i = 0; i < 16; i++)
      wr(32'd5, 32'h0040_0000 + (i << 12), (i << 12) | 32'h0F);
    pid = 32'd5;
    read_addr = 32'h0040_5000;
    invalidate = 1'b1;
    tick();
    invalidate = 1'b0;
    wr(32'd5, 32'h004A_A000, 32'h000A_A00F);
    rd("inv_gone", 32'd5, 32'h0040_5000, 32'd0);
    rd("inv_new", 32'd5, 32'h004A_A000, 32'h000A_A00F);
    rd("inv_s0", 32'd5, 32'h0040_0000, 32'h0000_000F);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
